// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

    localparam int DEF_DW     = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_NUM_RD = 2;

    // Address of the hardwired zero register when that feature is enabled.
    localparam int ZERO_ADDR  = 0;

    // Low bit index of field 'port' inside a packed vector of 'width'-bit fields.
    function automatic int port_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: decode reserves destinations, writeback releases them,
// and a registered count of outstanding results is kept alongside the busy bits.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rsv,
    input  logic [AW-1:0]        rsv_addr,
    input  logic                 we,
    input  logic [AW-1:0]        wa,
    input  logic [NUM_RD*AW-1:0] ra,
    output logic [NUM_RD-1:0]    busy,
    output logic [AW:0]          pend_cnt
);

    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             set_eff;
    logic             inc;
    logic             dec;
    logic [AW:0]      cnt_d;

    // Next busy vector and count; the set is applied after the clear so a same-address
    // reserve keeps the register busy for the newer producer.
    always_comb begin
        set_eff = rsv && !(ZERO_REG && (rsv_addr == AW'(ZERO_ADDR)));
        busy_d  = busy_q;
        if (we) begin
            busy_d[wa] = 1'b0;
        end
        if (set_eff) begin
            busy_d[rsv_addr] = 1'b1;
        end
        inc   = set_eff && !busy_q[rsv_addr];
        dec   = we && busy_q[wa] && !(set_eff && (rsv_addr == wa));
        cnt_d = pend_cnt;
        if (inc && !dec) begin
            cnt_d = pend_cnt + CNT_ONE;
        end else if (dec && !inc) begin
            cnt_d = pend_cnt - CNT_ONE;
        end
    end

    // Busy bits and outstanding count update together; reset drops every reservation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= '0;
            pend_cnt <= '0;
        end else begin
            busy_q   <= busy_d;
            pend_cnt <= cnt_d;
        end
    end

    // Raw busy flag of the register addressed by each read port.
    always_comb begin
        busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            busy[i] = busy_q[ra[port_lo(i, AW) +: AW]];
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Parametrised multi-read-port register file with zero register, write-to-read bypass
// and a busy scoreboard used by decode to stall on outstanding multi-cycle results.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [AW-1:0]        wa,
    input  logic [DW-1:0]        wd,
    input  logic [NUM_RD*AW-1:0] ra,
    output logic [NUM_RD*DW-1:0] rd,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic                 rsv,
    input  logic [AW-1:0]        rsv_addr,
    output logic [AW:0]          pend_cnt
);

    logic [DW-1:0]     mem [DEPTH];
    logic              write_ok;
    logic [NUM_RD-1:0] sb_busy;
    logic [AW-1:0]     ra_i;

    assign write_ok = we && !(ZERO_REG && (wa == AW'(ZERO_ADDR)));

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .rsv      (rsv),
        .rsv_addr (rsv_addr),
        .we       (we),
        .wa       (wa),
        .ra       (ra),
        .busy     (sb_busy),
        .pend_cnt (pend_cnt)
    );

    // Storage: cleared on reset so contents are never X, otherwise written from writeback.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (write_ok) begin
            mem[wa] <= wd;
        end
    end

    // Per-port read mux: zero register first, then same-cycle forwarding, then storage.
    always_comb begin
        rd      = '0;
        rd_busy = '0;
        ra_i    = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra_i = ra[port_lo(i, AW) +: AW];
            if (ZERO_REG && (ra_i == AW'(ZERO_ADDR))) begin
                rd[port_lo(i, DW) +: DW] = '0;
                rd_busy[i]               = 1'b0;
            end else if (BYPASS && we && (wa == ra_i)) begin
                rd[port_lo(i, DW) +: DW] = wd;
                rd_busy[i]               = 1'b0;
            end else begin
                rd[port_lo(i, DW) +: DW] = mem[ra_i];
                rd_busy[i]               = sb_busy[i];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: default configuration, a no-zero/no-bypass variant,
// and a small three-port, eight-entry variant.
module tb_regfile_mp_sb;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Instance A: DW=32, DEPTH=32, NUM_RD=2, ZERO_REG=1, BYPASS=1
    logic        a_we, a_rsv;
    logic [4:0]  a_wa, a_rsv_addr;
    logic [31:0] a_wd;
    logic [9:0]  a_ra;
    logic [63:0] a_rd;
    logic [1:0]  a_rb;
    logic [5:0]  a_pc;

    // Instance B: ZERO_REG=0, BYPASS=0
    logic        b_we, b_rsv;
    logic [4:0]  b_wa, b_rsv_addr;
    logic [31:0] b_wd;
    logic [9:0]  b_ra;
    logic [63:0] b_rd;
    logic [1:0]  b_rb;
    logic [5:0]  b_pc;

    // Instance C: DEPTH=8, NUM_RD=3, ZERO_REG=1, BYPASS=1
    logic        c_we, c_rsv;
    logic [2:0]  c_wa, c_rsv_addr;
    logic [31:0] c_wd;
    logic [8:0]  c_ra;
    logic [95:0] c_rd;
    logic [2:0]  c_rb;
    logic [3:0]  c_pc;

    int checks = 0;
    int errors = 0;

    regfile_mp_sb #(.DW(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .we(a_we), .wa(a_wa), .wd(a_wd), .ra(a_ra), .rd(a_rd),
        .rd_busy(a_rb), .rsv(a_rsv), .rsv_addr(a_rsv_addr), .pend_cnt(a_pc)
    );

    regfile_mp_sb #(.DW(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(b_we), .wa(b_wa), .wd(b_wd), .ra(b_ra), .rd(b_rd),
        .rd_busy(b_rb), .rsv(b_rsv), .rsv_addr(b_rsv_addr), .pend_cnt(b_pc)
    );

    regfile_mp_sb #(.DW(32), .DEPTH(8), .NUM_RD(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .we(c_we), .wa(c_wa), .wd(c_wd), .ra(c_ra), .rd(c_rd),
        .rd_busy(c_rb), .rsv(c_rsv), .rsv_addr(c_rsv_addr), .pend_cnt(c_pc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        a_we = 1'b0; a_rsv = 1'b0; a_wa = '0; a_rsv_addr = '0; a_wd = '0; a_ra = '0;
        b_we = 1'b0; b_rsv = 1'b0; b_wa = '0; b_rsv_addr = '0; b_wd = '0; b_ra = '0;
        c_we = 1'b0; c_rsv = 1'b0; c_wa = '0; c_rsv_addr = '0; c_wd = '0; c_ra = '0;

        // Initial reset
        tick();
        chk("init_pend_a", 64'(a_pc), 64'(0));
        chk("init_pend_b", 64'(b_pc), 64'(0));
        chk("init_pend_c", 64'(c_pc), 64'(0));
        chk("init_busy_a", 64'(a_rb), 64'(0));
        rst_n = 1'b1;

        // 1. Reset clear, overriding write and reserve in the same cycle
        a_we = 1'b1; a_wa = 5'd5; a_wd = 32'hDEADBEEF;
        tick();
        a_we = 1'b0; a_ra = {5'd6, 5'd5};
        #1;
        chk("r5_written", 64'(a_rd[31:0]), 64'(32'hDEADBEEF));
        rst_n = 1'b0; a_we = 1'b1; a_wa = 5'd5; a_wd = 32'h1234; a_rsv = 1'b1; a_rsv_addr = 5'd6;
        tick();
        rst_n = 1'b1; a_we = 1'b0; a_rsv = 1'b0;
        #1;
        chk("rst_r5_zero", 64'(a_rd[31:0]), 64'(0));
        chk("rst_pend", 64'(a_pc), 64'(0));
        chk("rst_busy", 64'(a_rb), 64'(0));

        // 2. Zero register ignores writes and reservations
        a_we = 1'b1; a_wa = 5'd0; a_wd = 32'hFFFFFFFF;
        tick();
        a_we = 1'b0; a_rsv = 1'b1; a_rsv_addr = 5'd0;
        tick();
        a_rsv = 1'b0; a_ra = {5'd0, 5'd0};
        #1;
        chk("zero_rd", 64'(a_rd[31:0]), 64'(0));
        chk("zero_busy", 64'(a_rb), 64'(0));
        chk("zero_pend", 64'(a_pc), 64'(0));

        // 3. Bypass of same-cycle write data
        a_we = 1'b1; a_wa = 5'd7; a_wd = 32'h11;
        tick();
        a_wd = 32'h22; a_ra = {5'd0, 5'd7};
        #1;
        chk("bypass_same_cycle", 64'(a_rd[31:0]), 64'(32'h22));
        tick();
        a_we = 1'b0;
        #1;
        chk("bypass_after", 64'(a_rd[31:0]), 64'(32'h22));

        // 4. Reserve then release r3
        a_rsv = 1'b1; a_rsv_addr = 5'd3;
        tick();
        a_rsv = 1'b0; a_ra = {5'd0, 5'd3};
        #1;
        chk("sb_busy_set", 64'(a_rb[0]), 64'(1));
        chk("sb_pend_1", 64'(a_pc), 64'(1));
        a_we = 1'b1; a_wa = 5'd3; a_wd = 32'h33;
        #1;
        chk("sb_busy_bypass", 64'(a_rb[0]), 64'(0));
        chk("sb_data_bypass", 64'(a_rd[31:0]), 64'(32'h33));
        tick();
        a_we = 1'b0;
        #1;
        chk("sb_busy_cleared", 64'(a_rb[0]), 64'(0));
        chk("sb_pend_0", 64'(a_pc), 64'(0));

        // 5a. Reserve and write the same busy register: set wins
        a_rsv = 1'b1; a_rsv_addr = 5'd4;
        tick();
        a_we = 1'b1; a_wa = 5'd4; a_wd = 32'h44;
        tick();
        a_rsv = 1'b0; a_we = 1'b0; a_ra = {5'd0, 5'd4};
        #1;
        chk("same_pend", 64'(a_pc), 64'(1));
        chk("same_busy", 64'(a_rb[0]), 64'(1));
        chk("same_data", 64'(a_rd[31:0]), 64'(32'h44));

        // 5b. Reserve r8 while releasing busy r9: net count unchanged
        a_rsv = 1'b1; a_rsv_addr = 5'd9;
        tick();
        a_rsv_addr = 5'd8; a_we = 1'b1; a_wa = 5'd9; a_wd = 32'h99; a_ra = {5'd9, 5'd8};
        tick();
        a_rsv = 1'b0; a_we = 1'b0;
        #1;
        chk("swap_pend", 64'(a_pc), 64'(2));
        chk("swap_busy", 64'(a_rb), 64'(2'b01));
        chk("swap_data", 64'(a_rd[63:32]), 64'(32'h99));

        // Write to a non-busy register leaves the count alone
        a_we = 1'b1; a_wa = 5'd10; a_wd = 32'h5;
        tick();
        a_we = 1'b0;
        #1;
        chk("nonbusy_write_pend", 64'(a_pc), 64'(2));

        // B: no zero register, no bypass
        b_we = 1'b1; b_wa = 5'd0; b_wd = 32'hFFFFFFFF;
        tick();
        b_we = 1'b0; b_ra = {5'd0, 5'd0};
        #1;
        chk("nozero_r0", 64'(b_rd[31:0]), 64'(32'hFFFFFFFF));
        b_rsv = 1'b1; b_rsv_addr = 5'd0;
        tick();
        b_rsv = 1'b0;
        #1;
        chk("nozero_pend", 64'(b_pc), 64'(1));
        chk("nozero_busy", 64'(b_rb[0]), 64'(1));
        b_we = 1'b1; b_wa = 5'd7; b_wd = 32'h11;
        tick();
        b_wd = 32'h22; b_ra = {5'd0, 5'd7};
        #1;
        chk("nobypass_old", 64'(b_rd[31:0]), 64'(32'h11));
        tick();
        b_we = 1'b0;
        #1;
        chk("nobypass_new", 64'(b_rd[31:0]), 64'(32'h22));

        // C: fill the scoreboard of an eight-entry, three-port file
        for (int k = 1; k < 8; k++) begin
            c_rsv = 1'b1; c_rsv_addr = 3'(k);
            tick();
        end
        chk("fill_pend", 64'(c_pc), 64'(7));
        c_rsv_addr = 3'd7;
        tick();
        c_rsv = 1'b0;
        #1;
        chk("fill_repeat_pend", 64'(c_pc), 64'(7));
        c_ra = {3'd7, 3'd2, 3'd1};
        #1;
        chk("fill_busy3", 64'(c_rb), 64'(3'b111));
        c_we = 1'b1; c_wa = 3'd2; c_wd = 32'hA2;
        #1;
        chk("fill_bypass_busy", 64'(c_rb), 64'(3'b101));
        chk("fill_bypass_data", 64'(c_rd[63:32]), 64'(32'hA2));
        tick();
        c_we = 1'b0;
        #1;
        chk("fill_release_pend", 64'(c_pc), 64'(6));
        chk("fill_release_busy", 64'(c_rb), 64'(3'b101));
        chk("fill_release_data", 64'(c_rd[63:32]), 64'(32'hA2));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("midfill_rst_pend", 64'(c_pc), 64'(0));
        chk("midfill_rst_busy", 64'(c_rb), 64'(0));
        chk("midfill_rst_data", 64'(c_rd[63:0]), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
